// File: rtl/npu_sram_initiator.sv
// npu_sram_initiator
// Converts a valid/ready request stream from an NPU engine into SRAM pin
// activity and buffers read data in a small response FIFO, so that response
// back-pressure never loses data.
//
// Ports
//   CLK, RESETn        clock, async active-low reset
//   REQ_*              request channel (valid/ready, write, addr, wdata, wstrb)
//   RSP_*              read response channel (valid/ready, rdata = FIFO head)
//   SRAM_*             SRAM pins; SRAM_RDATA is valid the cycle after a read
//   BUSY               read in flight or response pending
module npu_sram_initiator #(
  parameter int AW        = 16,
  parameter int RSP_DEPTH = 3
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WRITE,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [31:0]   REQ_WDATA,
  input  logic [3:0]    REQ_WSTRB,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [31:0]   RSP_RDATA,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [31:0]   SRAM_WDATA,
  output logic [3:0]    SRAM_WREN,
  output logic          SRAM_CS,
  input  logic [31:0]   SRAM_RDATA,
  output logic          BUSY
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [PW-1:0] PLAST   = PW'(RSP_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(RSP_DEPTH);

  logic          inflight;
  logic [31:0]   mem [RSP_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          accept, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + PW'(1);
  endfunction

  // Read credit counts both buffered words and the read already on the SRAM
  // pins, so every returning word is guaranteed a slot. Only registered state
  // is used: no combinational path from RSP_READY to REQ_READY.
  assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign REQ_READY = RESETn & (REQ_WRITE | (used < DEPTH_C));
  assign accept    = REQ_VALID & REQ_READY;

  assign SRAM_ADDR  = REQ_ADDR;
  assign SRAM_WDATA = REQ_WDATA;
  assign SRAM_CS    = accept;
  assign SRAM_WREN  = (accept & REQ_WRITE) ? REQ_WSTRB : 4'b0000;

  assign push      = inflight;
  assign RSP_VALID = (count != '0);
  assign pop       = RSP_VALID & RSP_READY;
  assign RSP_RDATA = RSP_VALID ? mem[rptr] : 32'h0;
  assign BUSY      = inflight | RSP_VALID;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      inflight <= accept & ~REQ_WRITE;
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only count/pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= SRAM_RDATA;
  end

  // The credit rule must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RESETn)
    !(push && (count == CW'(RSP_DEPTH))));

endmodule

// File: doc/npu_sram_initiator.md
# npu_sram_initiator

Request-side initiator for the NPU on-chip SRAM port (word address, 32-bit data, 4-bit byte write enables, chip select, one-cycle pipelined read data gated by the registered chip select). It converts a valid/ready request stream from NPU engines into SRAM pin activity. It collects read data into a small response FIFO so response back-pressure never loses data. It sits between an NPU engine (DMA, weight loader) and one SRAM instance.

## Interface
- AW, 16, word address width, matching the SRAM.
- RSP_DEPTH, 3, response FIFO depth in words; minimum 2; 3 gives one read per cycle with RSP_READY held high.

- CLK  in  1  clock; all state on rising edge.
- RESETn  in  1  reset, asynchronous assert, active-low.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request ready; a request is accepted when REQ_VALID & REQ_READY.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  AW  word address.
- REQ_WDATA  in  32  write data.
- REQ_WSTRB  in  4  byte write strobes; bit n enables byte n (bits 8n+7:8n).
- RSP_VALID  out  1  read response valid.
- RSP_READY  in  1  read response ready; popped when RSP_VALID & RSP_READY.
- RSP_RDATA  out  32  read response data, FIFO head.
- SRAM_ADDR  out  AW  to SRAM ADDR.
- SRAM_WDATA  out  32  to SRAM WDATA.
- SRAM_WREN  out  4  to SRAM WREN.
- SRAM_CS  out  1  to SRAM CS.
- SRAM_RDATA  in  32  from SRAM RDATA; valid the cycle after a read access.
- BUSY  out  1  read in flight or response pending.

## Operation
- State: inflight (1 bit, read issued last cycle), response FIFO of RSP_DEPTH words with count 0..RSP_DEPTH, read/write pointers wrapping modulo RSP_DEPTH.
- REQ_READY: 1 for writes. For reads, (count + inflight) < RSP_DEPTH. It must not depend on RSP_READY, so there is no combinational path from RSP_READY. It is 0 while RESETn is low.
- SRAM pins are combinational from the request: SRAM_ADDR = REQ_ADDR, SRAM_WDATA = REQ_WDATA, SRAM_CS = accept, SRAM_WREN = (accept & REQ_WRITE) ? REQ_WSTRB : 4'b0000.
- Write with REQ_WSTRB = 0 still asserts SRAM_CS for one cycle. Memory is unchanged and no response is produced.
- Writes produce no response.
- Read accept sets inflight for the next cycle. When inflight is 1, SRAM_RDATA is pushed into the FIFO at the end of that cycle.
- Requests are issued in acceptance order. A read after a write to the same address returns the written data. A write after a read does not corrupt the earlier read data.
- The credit rule guarantees a free slot for every push. Push to a full FIFO is a design error; assert in simulation.
- Simultaneous push and pop: count unchanged, head advances, new word at tail. This includes count = 1, where the pushed word becomes the head next cycle.
- RSP_VALID = (count != 0). RSP_RDATA = head entry when valid, 32'h0 otherwise.
- BUSY = inflight | (count != 0).

## Timing
- Reset (RESETn low, asynchronous): inflight = 0, count = 0, pointers = 0. Outputs: RSP_VALID = 0, RSP_RDATA = 0, REQ_READY = 0, SRAM_CS = 0, SRAM_WREN = 0, BUSY = 0.
- Reset mid-operation discards the in-flight read and all buffered responses. SRAM_RDATA following reset release is ignored.
- Write: SRAM write occurs at the edge ending the accept cycle; zero added latency.
- Read: request accepted in cycle N, SRAM_RDATA sampled at the end of cycle N+1, RSP_VALID high in cycle N+2. Two-cycle accept-to-response latency.
- With RSP_DEPTH = 3 and RSP_READY held at 1, back-to-back reads accept every cycle and responses stream every cycle.
- With RSP_READY = 0, at most RSP_DEPTH reads are accepted, then REQ_READY (read) drops. Writes continue to be accepted.
- RSP_VALID, once high, stays high with RSP_RDATA stable until popped (no retraction).

## Test plan
- Reset check: hold RESETn low for 3 cycles with REQ_VALID = 1 -> REQ_READY = 0, SRAM_CS = 0, RSP_VALID = 0, RSP_RDATA = 0, BUSY = 0.
- Byte-strobe write then read: write 0xA5A5A5A5 to addr 0x10 with WSTRB = 4'hF, then 0x12345678 with WSTRB = 4'b0101, then read 0x10 -> RSP_RDATA = 0xA534A578 in cycle N+2 of the read accept.
- Streaming reads: preload addr 0..7 with value = addr*0x01010101, issue 8 back-to-back reads with RSP_READY = 1 -> REQ_READY never drops, 8 consecutive RSP_VALID cycles, data in order.
- Back-pressure: RSP_READY = 0, offer 5 reads -> exactly 3 accepted, REQ_READY (read) = 0 after that, a write in between is still accepted. Release RSP_READY -> 3 responses in order, then the remaining reads proceed.
- Reset mid-stream: assert RESETn low for 1 cycle with count = 2 and inflight = 1 -> RSP_VALID = 0 after reset, BUSY = 0, no stale response appears afterwards.
- Zero-strobe write: WSTRB = 0 to addr 0x20 holding 0xDEADBEEF -> SRAM_CS pulses once with SRAM_WREN = 0, and a subsequent read returns 0xDEADBEEF.
